// File: rtl/op_cache_pkg.sv
// Shared opcode encodings and width-generic bit helpers for the operation cache.
package op_cache_pkg;

  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_ADD3    = 3'd1;
  localparam logic [2:0] OP_MAC     = 3'd2;
  localparam logic [2:0] OP_HALT    = 3'd3;
  localparam logic [2:0] OP_POPCNT  = 3'd4;
  localparam logic [2:0] OP_BITREV  = 3'd5;
  localparam logic [2:0] OP_LOOPSET = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  // Helpers operate on a fixed container; callers pass their real width in w.
  localparam int unsigned FN_MAX_W = 64;

  function automatic logic [FN_MAX_W-1:0] popcount(input logic [FN_MAX_W-1:0] x,
                                                   input int unsigned w);
    logic [FN_MAX_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < FN_MAX_W; i++) begin
      if (i < w) n = n + FN_MAX_W'(x[i]);
    end
    return n;
  endfunction

  function automatic logic [FN_MAX_W-1:0] bit_reverse(input logic [FN_MAX_W-1:0] x,
                                                      input int unsigned w);
    logic [FN_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < FN_MAX_W; i++) begin
      if (i < w) r[w-1-i] = x[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/op_cache_alu.sv
// Combinational datapath: evaluates one cached opcode against the p0/p1 history.
module op_cache_alu
  import op_cache_pkg::*;
#(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned VAL_W  = 4
) (
  input  logic [2:0]        i_op,
  input  logic [VAL_W-1:0]  i_value,
  input  logic [DATA_W-1:0] i_p0,
  input  logic [DATA_W-1:0] i_p1,
  output logic [DATA_W-1:0] o_result,
  output logic              o_overflow
);

  // One spare bit above the MAC product keeps the trailing +v exact.
  localparam int unsigned FULL_W = 2 * DATA_W + 1;

  logic [FULL_W-1:0]   w_full;
  logic [FULL_W-1:0]   w_p0;
  logic [FULL_W-1:0]   w_p1;
  logic [FULL_W-1:0]   w_v;
  logic [FN_MAX_W-1:0] w_p0_ext;

  // Full-precision evaluation, then truncate and flag bits lost above DATA_W.
  always_comb begin
    w_p0     = FULL_W'(i_p0);
    w_p1     = FULL_W'(i_p1);
    w_v      = FULL_W'(i_value);
    w_p0_ext = FN_MAX_W'(i_p0);
    w_full   = w_p0;
    case (i_op)
      OP_ADD:    w_full = w_p0 + w_v;
      OP_ADD3:   w_full = w_p0 + w_p1 + w_v;
      OP_MAC:    w_full = w_p0 * w_p1 + w_v;
      OP_POPCNT: w_full = FULL_W'(popcount(w_p0_ext, DATA_W));
      OP_BITREV: w_full = FULL_W'(bit_reverse(w_p0_ext, DATA_W));
      default:   w_full = w_p0;
    endcase
    o_result   = w_full[DATA_W-1:0];
    o_overflow = ((i_op == OP_ADD) || (i_op == OP_ADD3) || (i_op == OP_MAC)) &&
                 (|w_full[FULL_W-1:DATA_W]);
  end

endmodule

// File: rtl/op_cache_exec.sv
// Operation cache: load opcode/value pairs, then replay them one per clock
// on a two-deep result history with a programmable loop start and HALT.
module op_cache_exec
  import op_cache_pkg::*;
#(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned VAL_W  = 4,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic [2:0]        op_code,
  input  logic [VAL_W-1:0]  value,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              cache_full,
  output logic              invalid_op,
  output logic              overflow,
  output logic              halted,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]        r_op_mem  [DEPTH];
  logic [VAL_W-1:0]  r_val_mem [DEPTH];

  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_pc;
  logic [CNT_W-1:0]  r_loop_start;
  logic [DATA_W-1:0] r_p0;
  logic [DATA_W-1:0] r_p1;
  logic [DATA_W-1:0] r_result;
  logic              r_result_valid;
  logic              r_invalid_op;
  logic              r_overflow;
  logic              r_halted;

  logic              w_full;
  logic              w_load_ok;
  logic              w_exec_ok;
  logic [2:0]        w_cur_op;
  logic [VAL_W-1:0]  w_cur_val;
  logic              w_loopset_ok;
  logic [CNT_W-1:0]  w_wrap_target;
  logic [CNT_W-1:0]  w_pc_inc;
  logic [CNT_W-1:0]  w_pc_next;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_ovf;

  op_cache_alu #(
    .DATA_W (DATA_W),
    .VAL_W  (VAL_W)
  ) u_alu (
    .i_op       (w_cur_op),
    .i_value    (w_cur_val),
    .i_p0       (r_p0),
    .i_p1       (r_p1),
    .o_result   (w_alu_result),
    .o_overflow (w_alu_ovf)
  );

  // Decode the entry under pc and work out where the program counter goes next.
  always_comb begin
    w_full       = (r_count == CNT_W'(DEPTH));
    w_load_ok    = !mode && (op_code != OP_ILLEGAL) && !w_full;
    w_exec_ok    = mode && (r_count != '0) && !r_halted;
    w_cur_op     = r_op_mem[r_pc[IDX_W-1:0]];
    w_cur_val    = r_val_mem[r_pc[IDX_W-1:0]];
    w_loopset_ok = ({{CNT_W{1'b0}}, w_cur_val} < {{VAL_W{1'b0}}, r_count});
    // A LOOPSET on the last entry must wrap to the start it is writing now.
    w_wrap_target = (w_cur_op == OP_LOOPSET && w_loopset_ok) ? CNT_W'(w_cur_val)
                                                             : r_loop_start;
    w_pc_inc  = r_pc + CNT_W'(1);
    w_pc_next = (w_pc_inc == r_count) ? w_wrap_target : w_pc_inc;
  end

  // Cache storage; contents are irrelevant after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (w_load_ok) begin
      r_op_mem[r_count[IDX_W-1:0]]  <= op_code;
      r_val_mem[r_count[IDX_W-1:0]] <= value;
    end
  end

  // Control and history registers for both load and execute modes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count        <= '0;
      r_pc           <= '0;
      r_loop_start   <= '0;
      r_p0           <= '0;
      r_p1           <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_invalid_op   <= 1'b0;
      r_overflow     <= 1'b0;
      r_halted       <= 1'b0;
    end else if (!mode) begin
      r_result_valid <= 1'b0;
      if (op_code == OP_ILLEGAL) begin
        r_invalid_op <= 1'b1;
      end else if (!w_full) begin
        r_count      <= r_count + CNT_W'(1);
        r_invalid_op <= 1'b0;
      end
    end else if (!w_exec_ok) begin
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_pc           <= w_pc_next;
      case (w_cur_op)
        OP_HALT: begin
          r_halted <= 1'b1;
          r_pc     <= r_pc;
        end
        OP_LOOPSET: begin
          if (w_loopset_ok) begin
            r_loop_start <= CNT_W'(w_cur_val);
            r_invalid_op <= 1'b0;
          end else begin
            r_invalid_op <= 1'b1;
          end
        end
        OP_ILLEGAL: ;
        default: begin
          r_result       <= w_alu_result;
          r_p1           <= r_p0;
          r_p0           <= w_alu_result;
          r_overflow     <= w_alu_ovf;
          r_result_valid <= 1'b1;
          r_invalid_op   <= 1'b0;
        end
      endcase
    end
  end

  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign cache_full   = w_full;
  assign invalid_op   = r_invalid_op;
  assign overflow     = r_overflow;
  assign halted       = r_halted;
  assign count        = r_count;

endmodule

// File: tb/tb_op_cache_exec.sv
// Scoreboard bench for op_cache_exec: a driver feeds directed and random
// commands through an instruction-level reference model; a monitor compares.
module tb_op_cache_exec;

  localparam int DATA_W = 10;
  localparam int VAL_W  = 4;
  localparam int DEPTH  = 32;
  localparam int CNT_W  = 6;
  localparam longint MODV = 64'd1 << DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              mode;
  logic [2:0]        op_code;
  logic [VAL_W-1:0]  value;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              cache_full;
  logic              invalid_op;
  logic              overflow;
  logic              halted;
  logic [CNT_W-1:0]  count;

  op_cache_exec #(
    .DATA_W (DATA_W),
    .VAL_W  (VAL_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .op_code      (op_code),
    .value        (value),
    .result       (result),
    .result_valid (result_valid),
    .cache_full   (cache_full),
    .invalid_op   (invalid_op),
    .overflow     (overflow),
    .halted       (halted),
    .count        (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint res;
    bit     rv;
    bit     ovf;
    bit     inv;
    bit     hlt;
    bit     full;
    int     cnt;
  } status_t;

  typedef struct {
    longint res;
    bit     ovf;
  } strobe_t;

  status_t st_q[$];
  strobe_t res_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference machine state (program as queues, history as plain integers).
  int     m_op[$];
  int     m_val[$];
  longint m_p0, m_p1, m_res;
  int     m_pc, m_ls;
  bit     m_halt, m_rv, m_ovf, m_inv;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint ones(input longint x);
    longint n = 0;
    longint t = x;
    while (t > 0) begin
      n += t % 2;
      t /= 2;
    end
    return n;
  endfunction

  function automatic longint rev(input longint x);
    longint r = 0;
    for (int i = 0; i < DATA_W; i++)
      if (((x / (64'd1 << i)) % 2) == 1) r += 64'd1 << (DATA_W - 1 - i);
    return r;
  endfunction

  function automatic void model_reset();
    m_op.delete();
    m_val.delete();
    m_p0 = 0; m_p1 = 0; m_res = 0;
    m_pc = 0; m_ls = 0;
    m_halt = 0; m_rv = 0; m_ovf = 0; m_inv = 0;
  endfunction

  function automatic void model_step(input bit md, input int op, input int v);
    if (!md) begin
      m_rv = 0;
      if (op == 7) m_inv = 1;
      else if (m_op.size() < DEPTH) begin
        m_op.push_back(op);
        m_val.push_back(v);
        m_inv = 0;
      end
    end else if (m_op.size() == 0 || m_halt) begin
      m_rv = 0;
    end else begin
      int     o  = m_op[m_pc];
      int     ov = m_val[m_pc];
      bit     adv = 1;
      longint full = 0;
      m_rv = 0;
      if (o == 3) begin
        m_halt = 1;
        adv = 0;
      end else if (o == 6) begin
        if (ov < m_op.size()) begin
          m_ls = ov;
          m_inv = 0;
        end else m_inv = 1;
      end else begin
        case (o)
          0: full = m_p0 + ov;
          1: full = m_p0 + m_p1 + ov;
          2: full = m_p0 * m_p1 + ov;
          4: full = ones(m_p0);
          default: full = rev(m_p0);
        endcase
        m_res = full % MODV;
        m_ovf = (o <= 2) && (full >= MODV);
        m_p1 = m_p0;
        m_p0 = m_res;
        m_rv = 1;
        m_inv = 0;
        res_q.push_back('{m_res, m_ovf});
      end
      if (adv) m_pc = (m_pc + 1 == m_op.size()) ? m_ls : m_pc + 1;
    end
  endfunction

  // Drive one command for the next rising edge and queue what must follow it.
  task automatic step(input bit md, input int op, input int v);
    status_t s;
    @(negedge clk);
    reset   = 1'b0;
    mode    = md;
    op_code = 3'(op);
    value   = VAL_W'(v);
    model_step(md, op, v);
    s.res = m_res; s.rv = m_rv; s.ovf = m_ovf; s.inv = m_inv; s.hlt = m_halt;
    s.cnt = m_op.size(); s.full = (m_op.size() == DEPTH);
    st_q.push_back(s);
  endtask

  task automatic load(input int op, input int v);
    step(1'b0, op, v);
  endtask

  task automatic exec(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 0, 0);
  endtask

  // Reset lands between edges so its asynchronous effect is observable.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_full", cache_full, 0);
    check("rst_invalid", invalid_op, 0);
    check("rst_overflow", overflow, 0);
    check("rst_halted", halted, 0);
    check("rst_count", count, 0);
    model_reset();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  function automatic int rand_op();
    int pick[7] = '{0, 1, 2, 4, 5, 6, 7};
    if ($urandom_range(0, 24) == 0) return 3;
    return pick[$urandom_range(0, 6)];
  endfunction

  // Monitor: per-cycle status against the queue, strobed results against res_q.
  initial begin
    status_t s;
    strobe_t e;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        check("result", result, s.res);
        check("result_valid", result_valid, s.rv);
        check("overflow", overflow, s.ovf);
        check("invalid_op", invalid_op, s.inv);
        check("halted", halted, s.hlt);
        check("count", count, s.cnt);
        check("cache_full", cache_full, s.full);
      end
      if (result_valid) begin
        if (res_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL strobe: got unexpected result %0d, required no strobe at %0t",
                   result, $time);
        end else begin
          e = res_q.pop_front();
          check("strobe_result", result, e.res);
          check("strobe_overflow", overflow, e.ovf);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mode = 1'b0; op_code = 3'd0; value = '0;

    do_reset();
    load(0, 5); load(0, 3);
    exec(4);
    settle();
    check("tp1_result", result, 16);
    check("tp1_count", count, 2);

    do_reset();
    load(0, 15); load(1, 15); load(2, 0);
    exec(6);
    settle();
    check("tp2_result", result, 322);
    check("tp2_overflow", overflow, 1);

    do_reset();
    for (int i = 0; i < 33; i++) load(0, i % 16);
    load(7, 0);
    load(1, 1);
    settle();
    check("tp3_full", cache_full, 1);
    check("tp3_count", count, 32);

    do_reset();
    load(7, 3); load(0, 2); load(7, 0); load(1, 4);
    exec(3);

    do_reset();
    load(0, 1); load(6, 1); load(0, 2);
    exec(5);
    settle();
    check("tp5_result", result, 5);

    do_reset();
    load(0, 1); load(6, 9); load(0, 2);
    exec(5);

    do_reset();
    load(0, 5); load(5, 0); load(4, 0); load(3, 0);
    exec(6);
    settle();
    check("tp6_halted", halted, 1);
    check("tp6_result", result, 2);
    load(0, 7);
    exec(2);
    do_reset();

    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 2) == 0) load(rand_op(), $urandom_range(0, 15));
        else step(1'b1, $urandom_range(0, 7), $urandom_range(0, 15));
      end
      if (r == 3) do_reset();
    end

    settle();
    check("leftover_strobes", res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
